// File: rtl/pp_accumulator.sv
// Shift-and-add accumulator: sums WIDTH unshifted partial-product rows, each
// weighted by its row index, into a 2*WIDTH-bit unsigned product.
module pp_accumulator #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     clear,
    input  logic                     pp_valid,
    input  logic [WIDTH-1:0]         pp_data,
    output logic                     pp_ready,
    output logic [2*WIDTH-1:0]       prod,
    output logic                     prod_valid,
    input  logic                     prod_ready,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] row_cnt
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ROW = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [2*WIDTH-1:0]   acc_r;
    logic [2*WIDTH-1:0]   acc_s;
    logic [2*WIDTH-1:0]   row_shifted_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_s;
    logic                 pp_ready_r;
    logic                 prod_valid_r;
    logic                 busy_r;

    // Weight the incoming row by its index before it is added.
    always_comb begin
        row_shifted_s = {{WIDTH{1'b0}}, pp_data} << cnt_r;
    end

    // Next-state, accumulator and row-counter logic; clear overrides everything.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = ACCUM;
                    acc_s   = '0;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                if (pp_valid) begin
                    acc_s = acc_r + row_shifted_s;
                    if (cnt_r == LAST_ROW) begin
                        cnt_s   = '0;
                        state_s = DONE;
                    end else begin
                        cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            DONE: begin
                if (prod_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
                acc_s   = '0;
                cnt_s   = '0;
            end
        endcase
        if (clear) begin
            state_s = IDLE;
            acc_s   = '0;
            cnt_s   = '0;
        end else begin
            state_s = state_s;
        end
    end

    // State registers; handshake flags are decoded from the next state so they
    // come straight out of flops yet line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            acc_r        <= '0;
            cnt_r        <= '0;
            pp_ready_r   <= 1'b0;
            prod_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            acc_r        <= acc_s;
            cnt_r        <= cnt_s;
            pp_ready_r   <= (state_s == ACCUM);
            prod_valid_r <= (state_s == DONE);
            busy_r       <= (state_s != IDLE);
        end
    end

    assign pp_ready   = pp_ready_r;
    assign prod_valid = prod_valid_r;
    assign busy       = busy_r;
    assign prod       = acc_r;
    assign row_cnt    = cnt_r;

endmodule

// File: tb/tb_pp_accumulator.sv
// Randomized directed bench for pp_accumulator; expected products come from
// plain multiplication of the operands the rows were generated from.
module tb_pp_accumulator;

    localparam int W  = 32;
    localparam int CW = $clog2(W);
    localparam int LIMIT = 400;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            clear;
    logic            pp_valid;
    logic [W-1:0]    pp_data;
    logic            pp_ready;
    logic [2*W-1:0]  prod;
    logic            prod_valid;
    logic            prod_ready;
    logic            busy;
    logic [CW-1:0]   row_cnt;

    int vectors;
    int miscompares;

    pp_accumulator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear      (clear),
        .pp_valid   (pp_valid),
        .pp_data    (pp_data),
        .pp_ready   (pp_ready),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .busy       (busy),
        .row_cnt    (row_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // IDLE garbage on pp_valid/pp_data must not leak into the fresh product.
    task automatic begin_product();
        pp_valid = 1'b1;
        pp_data  = $urandom;
        start    = 1'b1;
        step();
        start    = 1'b0;
        pp_valid = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_pp_ready", 64'(pp_ready), 64'd1);
        chk("start_row_cnt", 64'(row_cnt), 64'd0);
        chk("start_prod", prod, 64'd0);
    endtask

    task automatic feed(input logic [31:0] a, input logic [31:0] b, input int n_rows,
                        input bit bubbles, input int inject, output int cycles);
        int k;
        logic v;
        logic [63:0] bm;
        k = 0;
        cycles = 0;
        while (k < n_rows && cycles < LIMIT) begin
            v        = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            pp_valid = v;
            pp_data  = v ? (b[k] ? a : 32'd0) : $urandom;
            start    = (k == inject);
            step();
            if (v) k++;
            cycles++;
            bm = {32'd0, b} & ((64'd1 << k) - 64'd1);
            chk("row_cnt", 64'(row_cnt), 64'(k % W));
            chk("partial", prod, {32'd0, a} * bm);
            chk("prod_valid_timing", 64'(prod_valid), 64'(k == W));
        end
        pp_valid = 1'b0;
        start    = 1'b0;
        if (cycles >= LIMIT) chk("feed_timeout", 64'(k), 64'(n_rows));
    endtask

    task automatic check_done(input logic [31:0] a, input logic [31:0] b);
        chk("done_prod_valid", 64'(prod_valid), 64'd1);
        chk("done_pp_ready", 64'(pp_ready), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_prod", prod, mul(a, b));
    endtask

    task automatic release_done();
        prod_ready = 1'b1;
        step();
        chk("release_prod_valid", 64'(prod_valid), 64'd0);
        chk("release_busy", 64'(busy), 64'd0);
        chk("release_pp_ready", 64'(pp_ready), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] held;
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; pp_valid = 1'b0;
        pp_data = '0; prod_ready = 1'b0;
        #2;
        chk("rst_pp_ready", 64'(pp_ready), 64'd0);
        chk("rst_prod_valid", 64'(prod_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_row_cnt", 64'(row_cnt), 64'd0);
        chk("rst_prod", prod, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // All-ones rows, no bubbles, latency and one-cycle prod_valid.
        prod_ready = 1'b1;
        a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        begin_product();
        feed(a, b, W, 1'b0, -1, cyc);
        chk("latency", 64'(cyc + 1), 64'(W + 1));
        check_done(a, b);
        chk("all_ones_const", prod, 64'hFFFF_FFFE_0000_0001);
        step();
        chk("one_cycle_valid", 64'(prod_valid), 64'd0);
        chk("back_to_idle", 64'(busy), 64'd0);

        // Sparse product with random bubbles.
        a = 32'h0000_000F; b = 32'h0000_0005;
        begin_product();
        feed(a, b, W, 1'b1, -1, cyc);
        check_done(a, b);
        chk("sparse_const", prod, 64'h4B);
        release_done();

        // Back-pressure in DONE with start and row noise.
        prod_ready = 1'b0;
        a = $urandom; b = $urandom;
        begin_product();
        feed(a, b, W, 1'b1, -1, cyc);
        check_done(a, b);
        held = prod;
        for (int i = 0; i < 10; i++) begin
            start    = 1'($urandom_range(0, 1));
            pp_valid = 1'($urandom_range(0, 1));
            pp_data  = $urandom;
            step();
            chk("hold_prod", prod, held);
            chk("hold_prod_valid", 64'(prod_valid), 64'd1);
            chk("hold_pp_ready", 64'(pp_ready), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
        end
        start = 1'b0; pp_valid = 1'b0;
        release_done();

        // Asynchronous reset mid-product, then a trivial product.
        a = $urandom; b = $urandom;
        begin_product();
        feed(a, b, 17, 1'b1, -1, cyc);
        rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_pp_ready", 64'(pp_ready), 64'd0);
        chk("async_prod_valid", 64'(prod_valid), 64'd0);
        chk("async_row_cnt", 64'(row_cnt), 64'd0);
        chk("async_prod", prod, 64'd0);
        #3;
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", 64'(busy), 64'd0);
        begin_product();
        feed(32'd1, 32'd1, W, 1'b1, -1, cyc);
        check_done(32'd1, 32'd1);
        release_done();

        // clear beats start in IDLE; clear aborts mid-ACCUM.
        clear = 1'b1; start = 1'b1;
        step();
        clear = 1'b0; start = 1'b0;
        chk("clear_start_busy", 64'(busy), 64'd0);
        chk("clear_start_pp_ready", 64'(pp_ready), 64'd0);
        a = $urandom; b = $urandom;
        begin_product();
        feed(a, b, 5, 1'b0, -1, cyc);
        clear = 1'b1; pp_valid = 1'b1; pp_data = $urandom;
        step();
        clear = 1'b0; pp_valid = 1'b0;
        chk("clear_busy", 64'(busy), 64'd0);
        chk("clear_row_cnt", 64'(row_cnt), 64'd0);
        chk("clear_prod", prod, 64'd0);
        chk("clear_prod_valid", 64'(prod_valid), 64'd0);
        step();
        chk("clear_stays_idle", 64'(prod_valid), 64'd0);

        // start at row 10 is ignored.
        a = $urandom; b = $urandom;
        begin_product();
        feed(a, b, W, 1'b0, 10, cyc);
        chk("inject_latency", 64'(cyc), 64'(W));
        check_done(a, b);
        release_done();

        // Random operands with bubbles.
        for (int t = 0; t < 4; t++) begin
            a = $urandom; b = $urandom;
            begin_product();
            feed(a, b, W, 1'b1, -1, cyc);
            check_done(a, b);
            release_done();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pp_accumulator.md
PP_ACCUMULATOR -- requirements
Module: pp_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: partial-product width and row count.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port start, input, 1: begin a new product; sampled only in IDLE.
REQ-005 Port clear, input, 1: synchronous abort to IDLE.
REQ-006 Port pp_valid, input, 1: pp_data holds a valid partial-product row.
REQ-007 Port pp_data, input, WIDTH: row k of the product, i.e. A AND B[k], unshifted.
REQ-008 Port pp_ready, output, 1: the block accepts a row this cycle.
REQ-009 Port prod, output, 2*WIDTH: accumulated product.
REQ-010 Port prod_valid, output, 1: prod is final.
REQ-011 Port prod_ready, input, 1: downstream consumes prod.
REQ-012 Port busy, output, 1: high in ACCUM or DONE.
REQ-013 Port row_cnt, output, clog2(WIDTH): index of the next row expected.

Function
REQ-014 The block SHALL implement a three-state FSM with states IDLE, ACCUM and DONE.
REQ-015 IDLE: pp_ready=0 and prod_valid=0; on start=1 and clear=0, acc<=0, row_cnt<=0, next state ACCUM.
REQ-016 ACCUM: pp_ready=1; a row transfers when pp_valid=1 and pp_ready=1.
REQ-017 On each transfer: acc <= acc + (zero-extended pp_data << row_cnt), modulo 2^(2*WIDTH), and row_cnt increments.
REQ-018 pp_valid low in ACCUM SHALL stall with no state change; bubbles are unlimited.
REQ-019 A transfer with row_cnt=WIDTH-1 SHALL move the FSM to DONE; row_cnt wraps to 0.
REQ-020 DONE: prod_valid=1 and pp_ready=0; prod and prod_valid hold stable while prod_ready=0.
REQ-021 DONE with prod_ready=1 SHALL go to IDLE next cycle; prod_valid deasserts in that same next cycle.
REQ-022 prod SHALL always drive acc; it is meaningful only while prod_valid=1.
REQ-023 Latency: prod_valid asserts in the cycle after the WIDTH-th row transfer; minimum start-to-prod_valid latency is WIDTH+1 cycles.
REQ-024 start in ACCUM or DONE SHALL be ignored.
REQ-025 pp_valid outside ACCUM SHALL be ignored, with no transfer.
REQ-026 clear=1 in any state SHALL force IDLE next cycle, with acc=0 and row_cnt=0.
REQ-027 clear SHALL take priority over start, row transfer and prod_ready in the same cycle.
REQ-028 busy SHALL equal (state != IDLE).
REQ-029 The output product SHALL be unsigned.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, acc=0, row_cnt=0, pp_ready=0, prod_valid=0 and busy=0, asynchronously and including mid-ACCUM.
REQ-031 After rst_n deasserts, the block SHALL wait for start; no partial state survives reset.

Verification
REQ-032 All rows 0xFFFFFFFF, pp_valid held high, prod_ready=1 -> prod=0xFFFFFFFE00000001; prod_valid high exactly 1 cycle; prod_valid in cycle WIDTH+1 after start.
REQ-033 A=0x0000000F, B=0x00000005 (rows 0 and 2 = 0xF, others 0), random pp_valid bubbles -> prod=0x4B; row count is unaffected by the bubbles.
REQ-034 prod_ready held low for 10 cycles in DONE -> prod and prod_valid stable throughout; pp_ready=0; start pulses ignored; IDLE one cycle after prod_ready=1.
REQ-035 rst_n pulsed low after 17 rows -> outputs zero immediately; a fresh start with A=B=1 (row 0 = 1, others 0) -> prod=1.
REQ-036 clear and start asserted together in IDLE -> stays IDLE; clear asserted in ACCUM at row 5 -> IDLE, row_cnt=0, no prod_valid.
REQ-037 start asserted in ACCUM at row 10 -> ignored; the product still completes after 32 rows with the correct value.
